pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised pipeline hazard/control unit for the in-order CPU.
//  - Tracks every in-flight writer downstream of ID in a shift scoreboard.
//  - Generates per-operand forwarding selects, load-use stalls with bubble injection,
//    redirect flushes and the sticky halt.
//  - Replaces the fixed 3-stage forward logic and the one-shot LW stall tracker.
//  - Supports any stage count and any load-data latency.
// PARAMETERS
//  NUM_STAGES     3  tracked stages after ID (0=EX, 1=MEM, 2=WB ...), >=2
//  REG_ADDR_W     4  register address width
//  LOAD_LAT       1  first stage index whose output carries load data (1=MEM); < NUM_STAGES
//  REDIRECT_STAGE 1  stage index that raises redirect (taken branch/jump); < NUM_STAGES
//  CNT_W          16 stall counter width
//  (SW = $clog2(NUM_STAGES+1))
// PORTS
//  clk          in  1            clock
//  rst_n        in  1            async active-low reset
//  id_valid     in  1            ID holds a real instruction
//  id_rd1_en    in  1            operand 1 is read
//  id_rd1_addr  in  REG_ADDR_W   operand 1 register
//  id_rd2_en    in  1            operand 2 is read
//  id_rd2_addr  in  REG_ADDR_W   operand 2 register
//  id_wr_en     in  1            instruction writes a register
//  id_wr_addr   in  REG_ADDR_W   destination register
//  id_is_load   in  1            instruction is LW
//  id_is_hlt    in  1            instruction is HLT
//  redirect     in  1            stage REDIRECT_STAGE redirects PC this cycle
//  fwd_sel1     out SW           0 = regfile, s+1 = forward from stage s output
//  fwd_sel2     out SW           same, for operand 2
//  stall        out 1            hold PC and IF/ID this cycle
//  flush_ifid   out 1            clear IF/ID at next edge
//  flush_idex   out 1            clear ID/EX (stage 0 entry) at next edge
//  issue        out 1            ID instruction enters stage 0 at next edge
//  stg_valid    out NUM_STAGES   scoreboard valid bits, bit s = stage s
//  hlt          out 1            sticky halt, registered
//  stall_cnt    out CNT_W        saturating count of stall cycles
// BEHAVIOUR
//  - Reset (async, rst_n low): all scoreboard entries invalid, hlt=0, stall_cnt=0.
//    Combinational outputs follow from the empty scoreboard: fwd_sel*=0, stall=0, issue=id_valid.
//  - Scoreboard entry fields: {valid, wr_en, wr_addr, is_load, is_hlt}.
//    Every non-halted edge shifts entry s to s+1; the last entry drops out.
//    Stage 0 loads the ID fields when issue=1, else a bubble (valid=0).
//  - Match per operand: valid & wr_en & rd_en & addr equal.
//    The youngest matching stage (lowest s) wins; fwd_sel = s+1.
//  - Load-use: the winning stage holds a load with s < LOAD_LAT -> stall=1, fwd_sel reported 0.
//    The load keeps advancing, so the stall lasts LOAD_LAT-s cycles, then forwards from LOAD_LAT.
//  - issue = id_valid & ~stall & ~redirect & ~front_hlt.
//    front_hlt = any valid is_hlt entry, or hlt=1. Instructions after HLT never issue.
//  - Redirect has priority over stall. In the redirect cycle: stall=0, flush_ifid=1, flush_idex=1.
//    Entries 0..REDIRECT_STAGE-1 are invalidated at the edge instead of shifting.
//    Older stages shift normally.
//  - flush_idex is also 1 on any cycle issue=0 (bubble). flush_ifid=1 only on redirect.
//  - Halt: hlt sets at the edge where a valid is_hlt entry leaves stage NUM_STAGES-1.
//    It then holds until reset and freezes the scoreboard.
//    A halt flushed by redirect never asserts hlt.
//  - stall_cnt increments on each cycle with stall=1 and saturates at all-ones.
//  - Reset mid-stall or mid-flush: everything clears immediately; there are no partial bubbles after release.
//  - Simultaneous stall and redirect: redirect wins (see above).
//    Operand 1 and operand 2 may match different stages independently.
// CONFIGURATION
//  PIPE_HZD_R0_ZERO_EN
//  - Defined: register 0 is hardwired zero. Reads of addr 0 never match (fwd_sel=0, never stall).
//    Writes to addr 0 enter the scoreboard with wr_en forced 0.
//  - Undefined: addr 0 is treated like any other register.
// TESTING
//  1. ADD r3 issued; next instr reads r3 on op1 -> fwd_sel1=1, stall=0. Next cycle a reader
//     -> fwd_sel1=2.
//  2. LW r5 issued; next instr reads r5 on op2 (LOAD_LAT=1) -> stall=1 for 1 cycle,
//     stg_valid[0]=0 bubble, then fwd_sel2=2, stall_cnt=1.
//  3. Writers r2 in stages 0 and 2, reader r2 -> fwd_sel1=1 (youngest wins).
//  4. Load-use stall and redirect in the same cycle -> stall=0, flush_ifid=flush_idex=1,
//     stg_valid[0] cleared, stage 1 entry advances to 2.
//  5. HLT issued, then id_valid=1 for 5 cycles -> issue=0 after HLT, hlt=1 NUM_STAGES cycles
//     after HLT issue, stg_valid frozen; rst_n pulse -> hlt=0, stg_valid=0.
//  6. Macro defined: reader of r0 behind writer r0 -> fwd_sel1=0, stall=0.
//     Macro undefined: same stimulus -> fwd_sel1=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request / hazard-control response bundle for pipe_hazard_ctrl.
// The master drives the decoded ID instruction and redirect; the slave returns the control decisions.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned REG_ADDR_W = 4,
  parameter int unsigned CNT_W      = 16
);
  localparam int unsigned SW = $clog2(NUM_STAGES + 1);

  logic                  id_valid;
  logic                  id_rd1_en;
  logic [REG_ADDR_W-1:0] id_rd1_addr;
  logic                  id_rd2_en;
  logic [REG_ADDR_W-1:0] id_rd2_addr;
  logic                  id_wr_en;
  logic [REG_ADDR_W-1:0] id_wr_addr;
  logic                  id_is_load;
  logic                  id_is_hlt;
  logic                  redirect;
  logic [SW-1:0]         fwd_sel1;
  logic [SW-1:0]         fwd_sel2;
  logic                  stall;
  logic                  flush_ifid;
  logic                  flush_idex;
  logic                  issue;
  logic [NUM_STAGES-1:0] stg_valid;
  logic                  hlt;
  logic [CNT_W-1:0]      stall_cnt;

  modport master (
    output id_valid, id_rd1_en, id_rd1_addr, id_rd2_en, id_rd2_addr,
           id_wr_en, id_wr_addr, id_is_load, id_is_hlt, redirect,
    input  fwd_sel1, fwd_sel2, stall, flush_ifid, flush_idex, issue,
           stg_valid, hlt, stall_cnt
  );

  modport slave (
    input  id_valid, id_rd1_en, id_rd1_addr, id_rd2_en, id_rd2_addr,
           id_wr_en, id_wr_addr, id_is_load, id_is_hlt, redirect,
    output fwd_sel1, fwd_sel2, stall, flush_ifid, flush_idex, issue,
           stg_valid, hlt, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/control unit: shift scoreboard of in-flight writers, forwarding, load-use stall,
// redirect flush and sticky halt. Optional macro PIPE_HZD_R0_ZERO_EN makes register 0 hardwired zero.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned REG_ADDR_W     = 4,
  parameter int unsigned LOAD_LAT       = 1,
  parameter int unsigned REDIRECT_STAGE = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int unsigned SW = $clog2(NUM_STAGES + 1);

  typedef enum logic {HS_RUN, HS_HALTED} halt_state_e;

  halt_state_e           state_q, state_d;
  logic [NUM_STAGES-1:0] sb_valid, sb_wr_en, sb_load, sb_hlt;
  logic [REG_ADDR_W-1:0] sb_addr [NUM_STAGES];
  logic                  hlt_q;
  logic                  rd1_en, rd2_en, wr_en_eff;
  logic                  use1, use2;
  logic [SW-1:0]         sel1, sel2;
  logic                  stall_c, issue_c, front_hlt;
  logic [CNT_W-1:0]      cnt_q;

  // Operand lookup: scanning oldest to youngest lets the youngest match overwrite.
  always_comb begin
`ifdef PIPE_HZD_R0_ZERO_EN
    rd1_en    = bus.id_rd1_en && (bus.id_rd1_addr != '0);
    rd2_en    = bus.id_rd2_en && (bus.id_rd2_addr != '0);
    wr_en_eff = bus.id_wr_en  && (bus.id_wr_addr  != '0);
`else
    rd1_en    = bus.id_rd1_en;
    rd2_en    = bus.id_rd2_en;
    wr_en_eff = bus.id_wr_en;
`endif
    sel1 = '0;
    sel2 = '0;
    use1 = 1'b0;
    use2 = 1'b0;
    for (int unsigned s = NUM_STAGES; s > 0; s--) begin
      if (sb_valid[s-1] && sb_wr_en[s-1] && rd1_en && (sb_addr[s-1] == bus.id_rd1_addr)) begin
        sel1 = SW'(s);
        use1 = sb_load[s-1] && ((s - 1) < LOAD_LAT);
      end
      if (sb_valid[s-1] && sb_wr_en[s-1] && rd2_en && (sb_addr[s-1] == bus.id_rd2_addr)) begin
        sel2 = SW'(s);
        use2 = sb_load[s-1] && ((s - 1) < LOAD_LAT);
      end
    end
  end

  always_comb begin
    stall_c        = (use1 || use2) && !bus.redirect;
    front_hlt      = (|(sb_valid & sb_hlt)) || hlt_q;
    issue_c        = bus.id_valid && !stall_c && !bus.redirect && !front_hlt;
    bus.fwd_sel1   = use1 ? '0 : sel1;
    bus.fwd_sel2   = use2 ? '0 : sel2;
    bus.stall      = stall_c;
    bus.flush_ifid = bus.redirect;
    bus.flush_idex = bus.redirect || !issue_c;
    bus.issue      = issue_c;
    bus.stg_valid  = sb_valid;
    bus.stall_cnt  = cnt_q;
  end

  // Halt FSM: state register / next-state / output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HS_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == HS_RUN && sb_valid[NUM_STAGES-1] && sb_hlt[NUM_STAGES-1]) state_d = HS_HALTED;
  end

  always_comb begin
    hlt_q   = (state_q == HS_HALTED);
    bus.hlt = hlt_q;
  end

  // Redirect kills the entries younger than the redirecting stage rather than shifting them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_valid <= '0;
      sb_wr_en <= '0;
      sb_load  <= '0;
      sb_hlt   <= '0;
      for (int unsigned s = 0; s < NUM_STAGES; s++) sb_addr[s] <= '0;
    end else if (state_q == HS_RUN) begin
      for (int unsigned s = 1; s < NUM_STAGES; s++) begin
        sb_valid[s] <= sb_valid[s-1] && !(bus.redirect && (s <= REDIRECT_STAGE));
        sb_wr_en[s] <= sb_wr_en[s-1];
        sb_load[s]  <= sb_load[s-1];
        sb_hlt[s]   <= sb_hlt[s-1];
        sb_addr[s]  <= sb_addr[s-1];
      end
      sb_valid[0] <= issue_c;
      sb_wr_en[0] <= wr_en_eff;
      sb_load[0]  <= bus.id_is_load;
      sb_hlt[0]   <= bus.id_is_hlt;
      sb_addr[0]  <= bus.id_wr_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt_q <= '0;
    else if (stall_c && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed scenarios then random traffic, checked against
// an in-flight instruction list model (age = stages travelled since issue).
module tb_pipe_hazard_ctrl;
  localparam int unsigned NS = 3;
  localparam int unsigned AW = 4;
  localparam int unsigned LL = 1;
  localparam int unsigned RS = 1;
  localparam int unsigned CW = 4;
  localparam int unsigned SW = $clog2(NS + 1);

  typedef struct {
    bit rst; bit v; bit r1e; logic [AW-1:0] r1a; bit r2e; logic [AW-1:0] r2a;
    bit we; logic [AW-1:0] wa; bit ld; bit ht; bit rd;
  } stim_t;

  typedef struct {
    int age; bit wr; logic [AW-1:0] addr; bit ld; bit ht;
  } inst_t;

  typedef struct {
    logic [SW-1:0] s1, s2; bit st, fi, fx, is; logic [NS-1:0] sv; bit h; logic [CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.NUM_STAGES(NS), .REG_ADDR_W(AW), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(
    .NUM_STAGES(NS), .REG_ADDR_W(AW), .LOAD_LAT(LL), .REDIRECT_STAGE(RS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  inst_t fl[$];
  bit    m_hlt;
  int    m_cnt;
  exp_t  exp_q[$];
  int    nvec = 0;
  int    nbad = 0;

  function automatic void model_lookup(input bit en, input logic [AW-1:0] a,
                                       output int sel, output bit lu);
    int best = NS;
    bit bl = 0;
    sel = 0;
    lu  = 0;
`ifdef PIPE_HZD_R0_ZERO_EN
    if (a == '0) en = 0;
`endif
    if (en)
      foreach (fl[i])
        if (fl[i].wr && fl[i].addr == a && fl[i].age < best) begin
          best = fl[i].age;
          bl   = fl[i].ld;
        end
    if (best < NS) begin
      if (bl && best < LL) lu = 1;
      else sel = best + 1;
    end
  endfunction

  task automatic step(input stim_t t);
    exp_t e;
    int sel1, sel2;
    bit lu1, lu2, fh, goes;
    inst_t nl[$];
    inst_t n;
    @(posedge clk);
    #1;
    rst_n           = !t.rst;
    bus.id_valid    = t.v;
    bus.id_rd1_en   = t.r1e;
    bus.id_rd1_addr = t.r1a;
    bus.id_rd2_en   = t.r2e;
    bus.id_rd2_addr = t.r2a;
    bus.id_wr_en    = t.we;
    bus.id_wr_addr  = t.wa;
    bus.id_is_load  = t.ld;
    bus.id_is_hlt   = t.ht;
    bus.redirect    = t.rd;
    if (t.rst) begin
      fl.delete();
      m_hlt = 0;
      m_cnt = 0;
    end
    model_lookup(t.r1e, t.r1a, sel1, lu1);
    model_lookup(t.r2e, t.r2a, sel2, lu2);
    e.st = (lu1 || lu2) && !t.rd;
    fh = m_hlt;
    foreach (fl[i]) if (fl[i].ht) fh = 1;
    e.is  = t.v && !e.st && !t.rd && !fh;
    e.s1  = SW'(sel1);
    e.s2  = SW'(sel2);
    e.fi  = t.rd;
    e.fx  = t.rd || !e.is;
    e.sv  = '0;
    foreach (fl[i]) e.sv[fl[i].age] = 1'b1;
    e.h   = m_hlt;
    e.cnt = CW'(m_cnt);
    exp_q.push_back(e);
    if (!t.rst) begin
      if (e.st && m_cnt < (1 << CW) - 1) m_cnt++;
      if (!m_hlt) begin
        goes = 0;
        foreach (fl[i]) begin
          if (fl[i].age == NS - 1 && fl[i].ht) goes = 1;
          if (!(t.rd && fl[i].age < RS) && fl[i].age + 1 < NS) begin
            n = fl[i];
            n.age++;
            nl.push_back(n);
          end
        end
        if (e.is) begin
          n.age = 0; n.wr = t.we; n.addr = t.wa; n.ld = t.ld; n.ht = t.ht;
`ifdef PIPE_HZD_R0_ZERO_EN
          if (t.wa == '0) n.wr = 0;
`endif
          nl.push_back(n);
        end
        fl = nl;
        m_hlt = goes;
      end
    end
  endtask

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("fwd_sel1",   32'(bus.fwd_sel1),   32'(e.s1));
      chk("fwd_sel2",   32'(bus.fwd_sel2),   32'(e.s2));
      chk("stall",      32'(bus.stall),      32'(e.st));
      chk("flush_ifid", 32'(bus.flush_ifid), 32'(e.fi));
      chk("flush_idex", 32'(bus.flush_idex), 32'(e.fx));
      chk("issue",      32'(bus.issue),      32'(e.is));
      chk("stg_valid",  32'(bus.stg_valid),  32'(e.sv));
      chk("hlt",        32'(bus.hlt),        32'(e.h));
      chk("stall_cnt",  32'(bus.stall_cnt),  32'(e.cnt));
    end
  end

  function automatic stim_t ins(bit v, bit r1e, int r1a, bit r2e, int r2a,
                                bit we, int wa, bit ld, bit ht, bit rd);
    stim_t t;
    t.rst = 0; t.v = v; t.r1e = r1e; t.r1a = AW'(r1a); t.r2e = r2e; t.r2a = AW'(r2a);
    t.we = we; t.wa = AW'(wa); t.ld = ld; t.ht = ht; t.rd = rd;
    return t;
  endfunction

  function automatic stim_t nop();
    return ins(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic stim_t rst_s();
    stim_t t = nop();
    t.rst = 1;
    return t;
  endfunction

  initial begin
    stim_t t;
    int halted_cycles;
    bus.id_valid = 0; bus.id_rd1_en = 0; bus.id_rd1_addr = '0; bus.id_rd2_en = 0;
    bus.id_rd2_addr = '0; bus.id_wr_en = 0; bus.id_wr_addr = '0; bus.id_is_load = 0;
    bus.id_is_hlt = 0; bus.redirect = 0;
    step(rst_s());
    t = rst_s(); t.v = 1; step(t);
    // Forwarding from stage 0 then stage 1
    step(ins(1, 0, 0, 0, 0, 1, 3, 0, 0, 0));
    step(ins(1, 1, 3, 0, 0, 0, 0, 0, 0, 0));
    step(ins(1, 1, 3, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) step(nop());
    // Load-use on operand 2
    step(ins(1, 0, 0, 0, 0, 1, 5, 1, 0, 0));
    step(ins(1, 0, 0, 1, 5, 1, 7, 0, 0, 0));
    step(ins(1, 0, 0, 1, 5, 1, 7, 0, 0, 0));
    repeat (3) step(nop());
    // Youngest writer wins
    step(ins(1, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    step(ins(1, 0, 0, 0, 0, 1, 9, 0, 0, 0));
    step(ins(1, 0, 0, 0, 0, 1, 2, 0, 0, 0));
    step(ins(1, 1, 2, 1, 9, 0, 0, 0, 0, 0));
    repeat (3) step(nop());
    // Load-use stall coinciding with redirect
    step(ins(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    step(ins(1, 0, 0, 0, 0, 1, 6, 1, 0, 0));
    step(ins(1, 1, 6, 0, 0, 0, 0, 0, 0, 1));
    repeat (3) step(nop());
    // HLT followed by more valid instructions, then reset
    step(ins(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    repeat (5) step(ins(1, 1, 4, 0, 0, 1, 4, 0, 0, 0));
    step(rst_s());
    step(nop());
    // Register 0 reader behind register 0 writer
    step(ins(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    step(ins(1, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    repeat (3) step(nop());
    // Random traffic with rare halts and periodic resets
    halted_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      t.rst = ($urandom_range(0, 299) == 0) || (halted_cycles > 4);
      t.v   = ($urandom_range(0, 7) != 0);
      t.r1e = $urandom_range(0, 1);
      t.r1a = AW'($urandom_range(0, 3));
      t.r2e = $urandom_range(0, 1);
      t.r2a = AW'($urandom_range(0, 3));
      t.we  = ($urandom_range(0, 3) != 0);
      t.wa  = AW'($urandom_range(0, 3));
      t.ld  = ($urandom_range(0, 3) == 0);
      t.ht  = ($urandom_range(0, 49) == 0);
      t.rd  = ($urandom_range(0, 9) == 0);
      step(t);
      halted_cycles = m_hlt ? halted_cycles + 1 : 0;
    end
    step(nop());
    @(negedge clk);
    @(negedge clk);
    nvec++;
    if (exp_q.size() != 0) begin
      nbad++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
